// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM duty ramp controller: state encoding and
// duty/period constants common to the controller and its period timer.
package pwm_ctrl_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int PWM_PERIOD = 1 << DUTY_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running phase counter that tracks the pwm block's counter, a registered
// end-of-period pulse, and a period divider that produces the ramp step event.
module pwm_period_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic div_clr,
  output logic period_tick,
  output logic step_evt
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DUTY_W-1:0] phase;
  logic [DIV_W-1:0]  div_cnt;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= '0;
      period_tick <= 1'b0;
    end else begin
      phase       <= phase + DUTY_W'(1);
      period_tick <= (phase == '1);
    end
  end

  // A command accept restarts the divider even if a tick lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_clr) begin
      div_cnt <= '0;
    end else if (period_tick) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign step_evt = period_tick && (div_cnt == DIV_LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / slew-rate controller: walks the pwm duty toward a commanded
// target by STEP every DIV PWM periods, with an immediate fault force-to-zero.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int STEP   = 1,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] cmd_duty,
  output logic              cmd_ready,
  input  logic              fault,
  input  logic              fault_clr,
  output logic [DUTY_W-1:0] PW,
  output logic              period_tick,
  output logic              busy,
  output logic              at_target,
  output logic              fault_active
);

  localparam logic [DUTY_W:0] STEP_X = (DUTY_W + 1)'(STEP);

  ctrl_state_t       state, state_nxt;
  logic [DUTY_W-1:0] target, target_nxt, pw_nxt, step_val;
  logic              accept, step_evt;

  logic        [DUTY_W:0]   up_sum;
  logic signed [DUTY_W+1:0] dn_diff;

  assign cmd_ready    = (state != ST_FAULT);
  assign accept       = cmd_valid && cmd_ready && !fault;
  assign busy         = (state == ST_RAMP);
  assign at_target    = (state == ST_IDLE) || (state == ST_HOLD);
  assign fault_active = (state == ST_FAULT);

  pwm_period_timer #(
    .DUTY_W (DUTY_W),
    .DIV    (DIV)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_clr     (accept),
    .period_tick (period_tick),
    .step_evt    (step_evt)
  );

  // Extra headroom bits keep the step from wrapping past full scale or below zero.
  always_comb begin
    up_sum   = {1'b0, PW} + STEP_X;
    dn_diff  = $signed({2'b00, PW}) - $signed({1'b0, STEP_X});
    step_val = target;
    if (target > PW) begin
      if (up_sum < {1'b0, target}) step_val = up_sum[DUTY_W-1:0];
    end else if (target < PW) begin
      if (dn_diff > $signed({2'b00, target})) step_val = dn_diff[DUTY_W-1:0];
    end
  end

  // Priority: fault, then FAULT-exit, then command accept, then step.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt  = state;
    pw_nxt     = PW;
    target_nxt = target;
    if (fault) begin
      state_nxt  = ST_FAULT;
      pw_nxt     = '0;
      target_nxt = '0;
    end else if (state == ST_FAULT) begin
      if (fault_clr) state_nxt = ST_IDLE;
    end else if (accept) begin
      target_nxt = cmd_duty;
      state_nxt  = (cmd_duty == PW) ? ST_HOLD : ST_RAMP;
    end else if (step_evt && (state == ST_RAMP)) begin
      pw_nxt = step_val;
      if (step_val == target) state_nxt = ST_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      PW     <= '0;
      target <= '0;
    end else begin
      state  <= state_nxt;
      PW     <= pw_nxt;
      target <= target_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench: instance A (STEP=16, DIV=1) runs against a cycle-level
// reference model; instance B (STEP=16, DIV=4) checks step spacing and async reset.
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;

  localparam int PERIOD = 256;
  localparam int A_STEP = 16;
  localparam int A_DIV  = 1;
  localparam int LIMIT  = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A
  logic       rst_n, cmd_valid, fault, fault_clr;
  logic [7:0] cmd_duty, pw;
  logic       cmd_ready, period_tick, busy, at_target, fault_active;

  // instance B
  logic       rst_n_b, cmd_valid_b, fault_b, fault_clr_b;
  logic [7:0] cmd_duty_b, pw_b;
  logic       cmd_ready_b, period_tick_b, busy_b, at_target_b, fault_active_b;

  pwm_ramp_ctrl #(.DUTY_W(8), .STEP(A_STEP), .DIV(A_DIV)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_duty(cmd_duty),
    .cmd_ready(cmd_ready), .fault(fault), .fault_clr(fault_clr), .PW(pw),
    .period_tick(period_tick), .busy(busy), .at_target(at_target),
    .fault_active(fault_active)
  );

  pwm_ramp_ctrl #(.DUTY_W(8), .STEP(16), .DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .cmd_valid(cmd_valid_b), .cmd_duty(cmd_duty_b),
    .cmd_ready(cmd_ready_b), .fault(fault_b), .fault_clr(fault_clr_b), .PW(pw_b),
    .period_tick(period_tick_b), .busy(busy_b), .at_target(at_target_b),
    .fault_active(fault_active_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model of instance A, expressed as counts since reset.
  typedef enum {M_IDLE, M_RAMP, M_HOLD, M_FAULT} mmode_t;
  mmode_t m_mode;
  int     m_pw, m_tgt, m_n, m_ticks;

  task automatic model_reset();
    m_mode = M_IDLE; m_pw = 0; m_tgt = 0; m_n = 0; m_ticks = 0;
  endtask

  task automatic model_edge();
    bit tick_pre, acc, stp;
    tick_pre = (m_n > 0) && (m_n % PERIOD == 0);
    acc      = !fault && (m_mode != M_FAULT) && cmd_valid;
    stp      = tick_pre && !acc && (m_ticks % A_DIV == A_DIV - 1);
    if (acc) m_ticks = 0;
    else if (tick_pre) m_ticks++;
    if (fault) begin
      m_pw = 0; m_tgt = 0; m_mode = M_FAULT;
    end else if (m_mode == M_FAULT) begin
      if (fault_clr) m_mode = M_IDLE;
    end else if (acc) begin
      m_tgt  = int'(cmd_duty);
      m_mode = (m_tgt == m_pw) ? M_HOLD : M_RAMP;
    end else if (stp && m_mode == M_RAMP) begin
      if (m_tgt > m_pw) m_pw = (m_pw + A_STEP > m_tgt) ? m_tgt : m_pw + A_STEP;
      else              m_pw = (m_pw - A_STEP < m_tgt) ? m_tgt : m_pw - A_STEP;
      if (m_pw == m_tgt) m_mode = M_HOLD;
    end
    m_n++;
  endtask

  task automatic compare_model(input string tag);
    logic [4:0] exp_f;
    exp_f = {(m_n > 0) && (m_n % PERIOD == 0), m_mode != M_FAULT, m_mode == M_RAMP,
             (m_mode == M_IDLE) || (m_mode == M_HOLD), m_mode == M_FAULT};
    check({tag, "_pw"}, pw, m_pw);
    check({tag, "_flags{tick,rdy,busy,at,flt}"},
          {period_tick, cmd_ready, busy, at_target, fault_active}, exp_f);
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_edge();
    #1;
    compare_model("model");
  endtask

  task automatic reset_a();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_duty = '0; fault = 1'b0; fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    compare_model("reset");
    rst_n = 1'b1;
  endtask

  task automatic issue_cmd(input logic [7:0] d);
    cmd_valid = 1'b1; cmd_duty = d;
    step_clk();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_change(output int v);
    int prev;
    prev = int'(pw);
    v = prev;
    for (int i = 0; i < LIMIT; i++) begin
      step_clk();
      if (int'(pw) != prev) begin
        v = int'(pw);
        break;
      end
    end
    check("pw_changed_within_budget", int'(pw) != prev, 1);
  endtask

  task automatic expect_ramp(input string tag, input int vals[$]);
    int v;
    foreach (vals[k]) begin
      wait_change(v);
      check(tag, v, vals[k]);
    end
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, cnt, v;
    int seq[$];
    int t_chg[$];
    int prev_b;

    rst_n_b = 1'b0; cmd_valid_b = 1'b0; cmd_duty_b = '0; fault_b = 1'b0; fault_clr_b = 1'b0;

    // 1. reset values and period tick spacing
    reset_a();
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_at_target", at_target, 1);
    first = -1;
    for (int i = 1; i <= 300; i++) begin
      step_clk();
      if (period_tick && first < 0) begin
        first = i;
        break;
      end
    end
    check("first_tick_clk", first, 256);
    cnt = 0;
    for (int i = 1; i <= 300; i++) begin
      step_clk();
      cnt++;
      if (period_tick) break;
    end
    check("tick_interval", cnt, 256);

    // 2. up-ramp from IDLE
    issue_cmd(8'd64);
    check("up_accept_pw_unchanged", pw, 0);
    check("up_busy", busy, 1);
    seq = '{16, 32, 48, 64};
    expect_ramp("up_ramp", seq);
    check("up_hold_busy", busy, 0);
    check("up_hold_at_target", at_target, 1);

    // 3. down-ramp with clamp
    issue_cmd(8'd10);
    seq = '{48, 32, 16, 10};
    expect_ramp("down_ramp", seq);
    check("down_hold_at_target", at_target, 1);

    // 4a. saturation at full scale
    issue_cmd(8'd0);
    seq = '{0};
    expect_ramp("to_zero", seq);
    check("zero_is_hold_not_idle", at_target, 1);
    issue_cmd(8'd255);
    seq = '{};
    for (int k = 1; k <= 15; k++) seq.push_back(16 * k);
    seq.push_back(255);
    expect_ramp("sat_ramp", seq);
    repeat (600) step_clk();
    check("sat_no_wrap", pw, 255);

    // fault pulse + clear to return to IDLE at PW=0
    fault = 1'b1; step_clk();
    fault = 1'b0; fault_clr = 1'b1; step_clk();
    fault_clr = 1'b0;
    check("cleared_pw", pw, 0);

    // 4b. retarget mid-ramp
    issue_cmd(8'd128);
    seq = '{16, 32};
    expect_ramp("retarget_pre", seq);
    issue_cmd(8'd16);
    check("retarget_accept_pw_unchanged", pw, 32);
    seq = '{16};
    expect_ramp("retarget_post", seq);
    check("retarget_hold", at_target, 1);
    check("retarget_busy", busy, 0);

    // 5. fault mid-ramp
    issue_cmd(8'd128);
    seq = '{32, 48};
    expect_ramp("pre_fault", seq);
    fault = 1'b1; cmd_valid = 1'b1; cmd_duty = 8'd200;
    step_clk();
    check("fault_pw", pw, 0);
    check("fault_active", fault_active, 1);
    check("fault_cmd_ready", cmd_ready, 0);
    repeat (5) step_clk();
    fault_clr = 1'b1; step_clk();
    fault_clr = 1'b0;
    check("clr_while_fault_high", fault_active, 1);
    fault = 1'b0;
    repeat (3) step_clk();
    check("fault_low_no_clr", fault_active, 1);
    check("fault_cmd_ignored_pw", pw, 0);
    cmd_valid = 1'b0;
    fault_clr = 1'b1; step_clk();
    fault_clr = 1'b0;
    check("fault_exit", fault_active, 0);
    check("fault_exit_ready", cmd_ready, 1);
    check("fault_exit_idle_at_target", at_target, 1);

    // randomized traffic against the model
    for (int i = 0; i < 20000; i++) begin
      cmd_valid = ($urandom_range(0, 299) == 0);
      cmd_duty  = 8'($urandom);
      if (fault) fault = ($urandom_range(0, 3) != 0);
      else       fault = ($urandom_range(0, 2999) == 0);
      fault_clr = ($urandom_range(0, 49) == 0);
      step_clk();
    end
    cmd_valid = 1'b0; fault = 1'b0; fault_clr = 1'b0;

    // 6. DIV=4 step spacing and asynchronous reset on instance B
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    cmd_valid_b = 1'b1; cmd_duty_b = 8'd200;
    @(posedge clk); #1;
    cmd_valid_b = 1'b0;
    prev_b = int'(pw_b);
    seq = '{};
    for (int i = 1; i <= 5000 && t_chg.size() < 3; i++) begin
      @(posedge clk); #1;
      if (int'(pw_b) != prev_b) begin
        prev_b = int'(pw_b);
        t_chg.push_back(i);
        seq.push_back(prev_b);
      end
    end
    check("b_step_count", t_chg.size(), 3);
    if (t_chg.size() == 3) begin
      check("b_interval_1", t_chg[1] - t_chg[0], 1024);
      check("b_interval_2", t_chg[2] - t_chg[1], 1024);
      check("b_pw_1", seq[0], 16);
      check("b_pw_3", seq[2], 48);
    end
    check("b_busy_mid_ramp", busy_b, 1);
    @(posedge clk);
    #3 rst_n_b = 1'b0;
    #1;
    check("b_async_pw", pw_b, 0);
    check("b_async_busy", busy_b, 0);
    check("b_async_at_target", at_target_b, 1);
    check("b_async_cmd_ready", cmd_ready_b, 1);
    check("b_async_fault_active", fault_active_b, 0);
    check("b_async_tick", period_tick_b, 0);
    @(posedge clk); #1;
    check("b_in_reset_pw", pw_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
